// File: rtl/pc_branch_sequencer_pkg.sv
// Shared constants for the PC/branch sequencer: word and offset widths, opcodes,
// FSM state encoding and the link register index.
package pc_branch_sequencer_pkg;

    localparam int WORD_W = 32;
    localparam int OFF_W  = 19;
    localparam int CNT_W  = 3;

    localparam logic [3:0] LINK_REG = 4'd15;

    localparam logic [4:0] OPC_BR_DEF  = 5'b10010;
    localparam logic [4:0] OPC_JR_DEF  = 5'b10100;
    localparam logic [4:0] OPC_JAL_DEF = 5'b10011;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CON_REQ  = 2'd1,
        ST_CON_WAIT = 2'd2,
        ST_RESOLVE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/pc_branch_sequencer_target_adder.sv
// Combinational next-PC candidates: the fall-through address and the
// PC-relative branch target with a sign-extended 19-bit offset.
module pc_branch_sequencer_target_adder
    import pc_branch_sequencer_pkg::*;
(
    input  logic [WORD_W-1:0] pc,
    input  logic [OFF_W-1:0]  off,
    output logic [WORD_W-1:0] pc_inc,
    output logic [WORD_W-1:0] pc_br
);

    logic signed [WORD_W-1:0] off_ext;

    assign off_ext = {{(WORD_W-OFF_W){off[OFF_W-1]}}, off};
    assign pc_inc  = pc + WORD_W'(1);
    assign pc_br   = pc_inc + $unsigned(off_ext);

endmodule

// File: rtl/pc_branch_sequencer.sv
// Program counter owner: resolves br/jr/jal after decode, handshaking with the
// condition flip-flop for conditional branches and with the control unit via start/busy/done.
module pc_branch_sequencer
    import pc_branch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CON_LAT  = 2,
    parameter logic [4:0]  OPC_BR   = OPC_BR_DEF,
    parameter logic [4:0]  OPC_JR   = OPC_JR_DEF,
    parameter logic [4:0]  OPC_JAL  = OPC_JAL_DEF
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [31:0] IR,
    input  logic        con_q,
    input  logic [31:0] ra_value,
    output logic        con_in,
    output logic [31:0] pc,
    output logic [31:0] link_data,
    output logic        link_we,
    output logic        taken,
    output logic        busy,
    output logic        done
);

    seq_state_t         state;
    seq_state_t         state_next;
    logic [4:0]         ir_op;
    logic [OFF_W-1:0]   ir_off;
    logic [CNT_W-1:0]   wait_cnt;
    logic               cond_q;
    logic [WORD_W-1:0]  pc_inc;
    logic [WORD_W-1:0]  pc_br;

    // Condition-select bits are decoded by the flip-flop itself, not here.
    logic unused_ir_bits;
    assign unused_ir_bits = ^IR[26:19];

    pc_branch_sequencer_target_adder u_target_adder (
        .pc     (pc),
        .off    (ir_off),
        .pc_inc (pc_inc),
        .pc_br  (pc_br)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (IR[31:27] == OPC_BR) ? ST_CON_REQ : ST_RESOLVE;
                end
            end
            ST_CON_REQ:  state_next = ST_CON_WAIT;
            ST_CON_WAIT: begin
                if (wait_cnt == '0) begin
                    state_next = ST_RESOLVE;
                end
            end
            ST_RESOLVE:  state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        con_in = (state == ST_CON_REQ);
        busy   = (state != ST_IDLE);
    end

    // Datapath and registered handshake outputs; done/taken/link_we are single-cycle pulses.
    always_ff @(posedge clk) begin
        if (clr) begin
            pc        <= RESET_PC;
            link_data <= '0;
            link_we   <= 1'b0;
            taken     <= 1'b0;
            done      <= 1'b0;
            wait_cnt  <= '0;
            ir_op     <= '0;
            ir_off    <= '0;
            cond_q    <= 1'b0;
        end else begin
            done    <= 1'b0;
            taken   <= 1'b0;
            link_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ir_op  <= IR[31:27];
                        ir_off <= IR[OFF_W-1:0];
                    end
                end
                ST_CON_REQ: begin
                    wait_cnt <= CNT_W'(CON_LAT - 1);
                end
                ST_CON_WAIT: begin
                    if (wait_cnt == '0) begin
                        cond_q <= con_q;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                ST_RESOLVE: begin
                    done <= 1'b1;
                    if (ir_op == OPC_BR) begin
                        pc    <= cond_q ? pc_br : pc_inc;
                        taken <= cond_q;
                    end else if (ir_op == OPC_JR) begin
                        pc    <= ra_value;
                        taken <= 1'b1;
                    end else if (ir_op == OPC_JAL) begin
                        link_data <= pc_inc;
                        link_we   <= 1'b1;
                        pc        <= ra_value;
                        taken     <= 1'b1;
                    end else begin
                        pc <= pc_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_branch_sequencer.sv
// Directed plus randomized bench for pc_branch_sequencer against an
// instruction-level model of PC, link register and handshake timing.
module tb_pc_branch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          CON_LAT  = 2;
    localparam logic [4:0]  OP_BR    = 5'b10010;
    localparam logic [4:0]  OP_JR    = 5'b10100;
    localparam logic [4:0]  OP_JAL   = 5'b10011;
    localparam logic [4:0]  OP_ADD   = 5'b00011;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [31:0] IR;
    logic        con_q;
    logic [31:0] ra_value;
    logic        con_in;
    logic [31:0] pc;
    logic [31:0] link_data;
    logic        link_we;
    logic        taken;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    // Architectural model state and expectations for the instruction in flight
    logic [31:0] m_pc;
    logic [31:0] m_link;
    logic [31:0] e_pc;
    logic [31:0] e_link;
    logic        e_taken;
    logic        e_lwe;
    logic        e_con;
    int          e_lat;

    always #5 clk = ~clk;

    pc_branch_sequencer #(
        .RESET_PC (RESET_PC),
        .CON_LAT  (CON_LAT)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .IR        (IR),
        .con_q     (con_q),
        .ra_value  (ra_value),
        .con_in    (con_in),
        .pc        (pc),
        .link_data (link_data),
        .link_we   (link_we),
        .taken     (taken),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Branch offset as a signed integer: 19-bit two's complement value.
    function automatic logic [31:0] offset_of(input logic [18:0] c);
        int v;
        v = int'(c);
        if (c[18]) v = v - 524288;
        return 32'(v);
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [7:0] mid, input logic [18:0] c);
        return {op, mid, c};
    endfunction

    // Present an instruction (at a negedge) and work out what it must do.
    task automatic launch(input logic [31:0] ir_v, input logic [31:0] ra_v, input logic cq);
        logic [4:0] op;
        op       = ir_v[31:27];
        IR       = ir_v;
        ra_value = ra_v;
        con_q    = cq;
        start    = 1'b1;
        e_con    = (op == OP_BR);
        e_lat    = e_con ? 3 + CON_LAT : 2;
        e_lwe    = (op == OP_JAL);
        e_link   = e_lwe ? m_pc + 32'd1 : m_link;
        if (op == OP_BR) begin
            e_taken = cq;
            e_pc    = cq ? m_pc + 32'd1 + offset_of(ir_v[18:0]) : m_pc + 32'd1;
        end else if (op == OP_JR || op == OP_JAL) begin
            e_taken = 1'b1;
            e_pc    = ra_v;
        end else begin
            e_taken = 1'b0;
            e_pc    = m_pc + 32'd1;
        end
        m_pc   = e_pc;
        m_link = e_link;
    endtask

    // Follow the launched instruction to its done pulse; returns at the done negedge.
    task automatic finish(input string tag, input bit poke);
        int cyc;
        int npulse;
        int nlwe;
        bit seen;
        cyc = 0; npulse = 0; nlwe = 0; seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1 && poke) begin
                IR    = mk_ir(OP_ADD, 8'h00, 19'h0);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            npulse += int'(con_in);
            nlwe   += int'(link_we);
            if (done) seen = 1'b1;
            else if (cyc == 1) check({tag, "_busy"}, 32'(busy), 32'd1);
        end
        check({tag, "_latency"}, 32'(cyc), 32'(e_lat));
        check({tag, "_pc"}, pc, e_pc);
        check({tag, "_taken"}, 32'(taken), 32'(e_taken));
        check({tag, "_link_data"}, link_data, e_link);
        check({tag, "_link_we"}, 32'(link_we), 32'(e_lwe));
        check({tag, "_link_we_count"}, 32'(nlwe), e_lwe ? 32'd1 : 32'd0);
        check({tag, "_con_in_count"}, 32'(npulse), e_con ? 32'd1 : 32'd0);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    task automatic run(input string tag, input logic [31:0] ir_v, input logic [31:0] ra_v, input logic cq);
        @(negedge clk);
        launch(ir_v, ra_v, cq);
        finish(tag, 1'b0);
    endtask

    initial begin
        int ndone;
        bit chain;
        int sel;
        logic [4:0]  rop;
        logic [31:0] rra;

        clr = 1'b1; start = 1'b0; IR = '0; con_q = 1'b0; ra_value = '0;
        m_pc = RESET_PC; m_link = '0;

        // Reset held for two cycles, then released
        repeat (2) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        check("reset_pc", pc, RESET_PC);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_con_in", 32'(con_in), 32'd0);
        check("reset_link_we", 32'(link_we), 32'd0);
        check("reset_taken", 32'(taken), 32'd0);
        check("reset_link_data", link_data, 32'd0);

        // Non-branch fall-through
        run("jr_to_10", mk_ir(OP_JR, 8'h00, 19'h0), 32'h10, 1'b0);
        run("add_at_10", mk_ir(OP_ADD, 8'h12, 19'h00123), 32'h0, 1'b1);

        // Conditional branches, forward, backward and not taken
        run("jr_to_20a", mk_ir(OP_JR, 8'h00, 19'h0), 32'h20, 1'b0);
        run("br_fwd", mk_ir(OP_BR, 8'h00, 19'h00008), 32'h0, 1'b1);
        run("jr_to_20b", mk_ir(OP_JR, 8'h00, 19'h0), 32'h20, 1'b0);
        run("br_back", mk_ir(OP_BR, 8'h00, 19'h7FFFC), 32'h0, 1'b1);
        run("jr_to_20c", mk_ir(OP_JR, 8'h00, 19'h0), 32'h20, 1'b0);
        run("br_not_taken", mk_ir(OP_BR, 8'h00, 19'h7FFFC), 32'h0, 1'b0);

        // Jump-and-link and address wrap
        run("jr_to_40", mk_ir(OP_JR, 8'h00, 19'h0), 32'h40, 1'b0);
        run("jal", mk_ir(OP_JAL, 8'h00, 19'h0), 32'h100, 1'b0);
        run("jr_to_max", mk_ir(OP_JR, 8'h00, 19'h0), 32'hFFFF_FFFF, 1'b0);
        run("add_wrap", mk_ir(OP_ADD, 8'h00, 19'h0), 32'h0, 1'b0);
        run("jr_self", mk_ir(OP_JR, 8'h00, 19'h0), m_pc, 1'b0);

        // start while busy must be dropped
        @(negedge clk);
        launch(mk_ir(OP_ADD, 8'h00, 19'h0), 32'h0, 1'b0);
        finish("add_poked", 1'b1);
        @(negedge clk);
        check("poke_ignored_busy", 32'(busy), 32'd0);
        check("poke_ignored_pc", pc, m_pc);
        @(negedge clk);
        launch(mk_ir(OP_BR, 8'h00, 19'h00010), 32'h0, 1'b1);
        finish("br_poked", 1'b1);
        @(negedge clk);
        check("br_poke_ignored_busy", 32'(busy), 32'd0);

        // start in the done cycle is accepted
        run("b2b_first", mk_ir(OP_ADD, 8'h00, 19'h0), 32'h0, 1'b0);
        launch(mk_ir(OP_BR, 8'h00, 19'h00003), 32'h0, 1'b1);
        finish("b2b_second", 1'b0);
        launch(mk_ir(OP_JAL, 8'h00, 19'h0), 32'h0000_0500, 1'b0);
        finish("b2b_third", 1'b0);

        // clr in the middle of a branch drops it
        @(negedge clk);
        launch(mk_ir(OP_BR, 8'h00, 19'h00008), 32'h0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("midclr_busy_before", 32'(busy), 32'd1);
        clr = 1'b1;
        @(negedge clk);
        check("midclr_pc", pc, RESET_PC);
        check("midclr_busy", 32'(busy), 32'd0);
        check("midclr_done", 32'(done), 32'd0);
        check("midclr_link_data", link_data, 32'd0);
        clr = 1'b0;
        m_pc = RESET_PC; m_link = '0;
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            ndone += int'(done);
        end
        check("midclr_no_done", 32'(ndone), 32'd0);
        check("midclr_pc_hold", pc, RESET_PC);

        // Randomized instruction stream
        for (int i = 0; i < 30; i++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0: rop = OP_BR;
                1: rop = OP_JR;
                2: rop = OP_JAL;
                default: rop = 5'($urandom);
            endcase
            rra = $urandom;
            if ($urandom_range(0, 4) == 0) rra = m_pc;
            chain = ($urandom_range(0, 1) == 1) && (i > 0);
            if (!chain) @(negedge clk);
            launch(mk_ir(rop, 8'($urandom), 19'($urandom)), rra, 1'($urandom));
            finish($sformatf("rnd%0d", i), ($urandom_range(0, 3) == 0));
        end

        @(negedge clk);
        check("final_busy", 32'(busy), 32'd0);
        check("final_pc", pc, m_pc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
